// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: byte-wide processor serial port to 8N1 UART.
// TX bytes are queued in a small FIFO and shifted out LSB first. RX frames
// land in a single holding register that the processor pops.
module serial_uart_bridge #(
   parameter int unsigned CLKS_PER_BIT  = 16,
   parameter int unsigned TX_DEPTH_LOG2 = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data_in,
   input  logic       wr_en_in,
   output logic       ready_out,
   input  logic       rd_en_in,
   output logic [7:0] rd_data_out,
   output logic       valid_out,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   output logic       tx_busy_out,
   output logic       rx_overrun_out,
   output logic       rx_frame_err_out
);

   localparam int unsigned DEPTH = 2 ** TX_DEPTH_LOG2;
   localparam int unsigned CW    = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0]          BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]          HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TX_DEPTH_LOG2:0] FIFO_FULL = (TX_DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]               fifo_mem [DEPTH];
   logic [TX_DEPTH_LOG2-1:0] wr_ptr;
   logic [TX_DEPTH_LOG2-1:0] rd_ptr;
   logic [TX_DEPTH_LOG2:0]   fifo_count;
   logic                     fifo_empty;
   logic                     fifo_push;
   logic                     fifo_pop;

   tx_state_t                tx_state;
   logic [7:0]               tx_shift;
   logic [CW-1:0]            tx_cnt;
   logic [2:0]               tx_bit;
   logic                     tx_line;

   assign fifo_empty = (fifo_count == '0);
   assign ready_out  = (fifo_count != FIFO_FULL);
   assign fifo_pop   = (tx_state == TX_IDLE) && !fifo_empty;
   // A push while full is still taken when the transmitter pops on the same edge.
   assign fifo_push  = wr_en_in && (ready_out || fifo_pop);

   assign tx_busy_out = (tx_state != TX_IDLE) || !fifo_empty;
   assign uart_tx_out = tx_line;

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clock) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr] <= wr_data_in;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // TX framer: start, 8 data bits LSB first, stop; each lasts CLKS_PER_BIT clocks
   always_ff @(posedge clock) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_line <= 1'b1;
               tx_cnt  <= '0;
               if (!fifo_empty) begin
                  tx_shift <= fifo_mem[rd_ptr];
                  tx_line  <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_line  <= tx_shift[0];
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_line  <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               tx_line <= 1'b1;
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   logic          rx_sync1;
   logic          rx_sync2;
   rx_state_t     rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_armed;
   logic          rx_complete;

   // Completion is the stop-bit mid-sample reading high
   assign rx_complete = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync2;

   // Two-flop synchroniser for the asynchronous RX line
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
      end else begin
         rx_sync1 <= uart_rx_in;
         rx_sync2 <= rx_sync1;
      end
   end

   // RX deframer; after a bad stop bit the line must go high before re-arming
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_state         <= RX_IDLE;
         rx_cnt           <= '0;
         rx_bit           <= '0;
         rx_shift         <= '0;
         rx_armed         <= 1'b1;
         rx_frame_err_out <= 1'b0;
      end else begin
         rx_frame_err_out <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (!rx_armed) begin
                  if (rx_sync2) begin
                     rx_armed <= 1'b1;
                  end
               end else if (!rx_sync2) begin
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  if (rx_sync2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit <= rx_bit + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_IDLE;
                  if (!rx_sync2) begin
                     rx_frame_err_out <= 1'b1;
                     rx_armed         <= 1'b0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Holding register: a read on the completion edge frees the slot for the new byte
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_data_out    <= '0;
         valid_out      <= 1'b0;
         rx_overrun_out <= 1'b0;
      end else if (rx_complete) begin
         if (!valid_out || rd_en_in) begin
            rd_data_out <= rx_shift;
            valid_out   <= 1'b1;
         end else begin
            rx_overrun_out <= 1'b1;
         end
      end else if (rd_en_in && valid_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Bench for serial_uart_bridge: directed and random TX/RX traffic against a
// queue-based reference model and an independent serial line decoder.
module tb_serial_uart_bridge;

   localparam int C     = 8;
   localparam int HALF  = C / 2;
   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] wr_data_in = '0;
   logic       wr_en_in = 1'b0;
   logic       ready_out;
   logic       rd_en_in = 1'b0;
   logic [7:0] rd_data_out;
   logic       valid_out;
   logic       uart_rx_in;
   logic       uart_tx_out;
   logic       tx_busy_out;
   logic       rx_overrun_out;
   logic       rx_frame_err_out;

   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fe_cnt = 0;

   assign uart_rx_in = loop ? uart_tx_out : rx_drv;

   serial_uart_bridge #(.CLKS_PER_BIT(C), .TX_DEPTH_LOG2(4)) dut (
      .clock            (clock),
      .reset            (reset),
      .wr_data_in       (wr_data_in),
      .wr_en_in         (wr_en_in),
      .ready_out        (ready_out),
      .rd_en_in         (rd_en_in),
      .rd_data_out      (rd_data_out),
      .valid_out        (valid_out),
      .uart_rx_in       (uart_rx_in),
      .uart_tx_out      (uart_tx_out),
      .tx_busy_out      (tx_busy_out),
      .rx_overrun_out   (rx_overrun_out),
      .rx_frame_err_out (rx_frame_err_out)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) if (rx_frame_err_out === 1'b1) fe_cnt++;

   // Reference model: accepted bytes queue up; the transmitter takes the head
   // whenever it is free and is then occupied for 10 bit times plus one clock.
   logic [7:0] m_q[$];
   logic [7:0] m_sent[$];
   int         m_edge = 0;
   int         m_free_at = 0;
   bit         m_pop;
   bit         m_full;

   always @(posedge clock) begin
      m_edge++;
      if (!reset) begin
         m_q.delete();
         m_free_at = 0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         m_pop  = (m_q.size() > 0) && (m_edge >= m_free_at);
         if (m_pop) begin
            m_sent.push_back(m_q.pop_front());
            m_free_at = m_edge + 10 * C + 1;
         end
         if (wr_en_in && (!m_full || m_pop)) m_q.push_back(wr_data_in);
      end
   end

   // Serial line decoder: samples each bit in its middle
   logic       mon_active = 1'b0;
   int         mon_t = 0;
   int         mon_start = 0;
   int         mon_stop_bad = 0;
   logic [7:0] mon_byte = '0;
   logic [7:0] mon_q[$];
   int         mon_start_q[$];

   always @(negedge clock) begin
      if (!reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (uart_tx_out === 1'b0) begin
            mon_active = 1'b1;
            mon_t      = 0;
            mon_start  = cyc;
         end
      end else begin
         mon_t++;
         if (mon_t == HALF && uart_tx_out !== 1'b0) begin
            mon_active = 1'b0;
         end else if (mon_t >= C + HALF && mon_t < 9 * C + HALF && ((mon_t - HALF) % C) == 0) begin
            mon_byte = {uart_tx_out, mon_byte[7:1]};
         end else if (mon_t == 9 * C + HALF) begin
            mon_q.push_back(mon_byte);
            mon_start_q.push_back(mon_start);
            if (uart_tx_out !== 1'b1) mon_stop_bad++;
            mon_active = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_data_in = b;
      wr_en_in   = 1'b1;
      tick();
      wr_en_in   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (tx_busy_out !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, {31'b0, tx_busy_out}, 32'd0);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (valid_out !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, {31'b0, valid_out}, 32'd1);
   endtask

   task automatic clear_streams();
      mon_q.delete();
      mon_start_q.delete();
      m_sent.delete();
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_count"}, mon_q.size(), m_sent.size());
      n = (mon_q.size() < m_sent.size()) ? mon_q.size() : m_sent.size();
      for (int unsigned i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), {24'b0, mon_q[i]}, {24'b0, m_sent[i]});
      check({tag, "_stop"}, mon_stop_bad, 0);
   endtask

   // Drives one 8N1 frame; rd_at selects the in-frame clock at which rd_en_in is pulsed
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int unsigned j = 0; j < 10 * C; j++) begin
         rx_drv   = fr[j / C];
         rd_en_in = (int'(j) == rd_at);
         tick();
      end
      rd_en_in = 1'b0;
      rx_drv   = 1'b1;
   endtask

   task automatic read_pulse();
      rd_en_in = 1'b1;
      tick();
      rd_en_in = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] rb;
      int         fe0;

      // Reset state
      tick();
      tick();
      check("rst_tx", {31'b0, uart_tx_out}, 32'd1);
      check("rst_ready", {31'b0, ready_out}, 32'd1);
      check("rst_valid", {31'b0, valid_out}, 32'd0);
      check("rst_rdata", {24'b0, rd_data_out}, 32'h00);
      check("rst_busy", {31'b0, tx_busy_out}, 32'd0);
      check("rst_ovr", {31'b0, rx_overrun_out}, 32'd0);
      check("rst_ferr", {31'b0, rx_frame_err_out}, 32'd0);
      reset = 1'b1;
      tick();

      // Single 8'hA5 frame, exact line waveform
      clear_streams();
      pat = 8'hA5;
      push(pat);
      check("a5_busy_push", {31'b0, tx_busy_out}, 32'd1);
      for (int unsigned t = 0; t < 10 * C; t++) begin
         logic expb;
         tick();
         if (t < C) expb = 1'b0;
         else if (t < 9 * C) expb = pat[t / C - 1];
         else expb = 1'b1;
         check($sformatf("a5_line_t%0d", t), {31'b0, uart_tx_out}, {31'b0, expb});
         if (t == 10 * C - 1) check("a5_busy_last", {31'b0, tx_busy_out}, 32'd1);
      end
      tick();
      check("a5_busy_end", {31'b0, tx_busy_out}, 32'd0);
      check("a5_line_end", {31'b0, uart_tx_out}, 32'd1);
      compare_stream("a5");

      // Back-to-back burst overflowing the FIFO
      clear_streams();
      for (int unsigned i = 0; i < 18; i++) begin
         push(8'(i));
         check($sformatf("burst_ready%0d", i), {31'b0, ready_out}, {31'b0, (m_q.size() != DEPTH)});
      end
      check("burst_full", {31'b0, ready_out}, 32'd0);
      wait_idle(20 * (10 * C + 1), "burst_idle");
      check("burst_nbytes", mon_q.size(), 17);
      for (int unsigned i = 0; i < mon_q.size() && i < 17; i++)
         check($sformatf("burst_val%0d", i), {24'b0, mon_q[i]}, i);
      for (int unsigned i = 1; i < mon_start_q.size(); i++)
         check($sformatf("burst_gap%0d", i), mon_start_q[i] - mon_start_q[i-1], 10 * C + 1);
      compare_stream("burst");

      // Random TX bytes with random gaps
      clear_streams();
      for (int unsigned i = 0; i < 6; i++) begin
         int gap;
         push(8'($urandom));
         check($sformatf("rnd_ready%0d", i), {31'b0, ready_out}, {31'b0, (m_q.size() != DEPTH)});
         gap = int'($urandom_range(0, 100));
         for (int g = 0; g < gap; g++) tick();
      end
      wait_idle(12 * (10 * C + 1), "rnd_idle");
      compare_stream("rnd");

      // RX 8'h3C then consume
      send_frame(8'h3C, 1'b1, -1);
      check("rx3c_valid", {31'b0, valid_out}, 32'd1);
      check("rx3c_data", {24'b0, rd_data_out}, 32'h3C);
      read_pulse();
      check("rx3c_consumed", {31'b0, valid_out}, 32'd0);
      check("rx3c_hold", {24'b0, rd_data_out}, 32'h3C);
      read_pulse();
      check("rx_rd_empty", {31'b0, valid_out}, 32'd0);

      // Overrun: second byte dropped while first unread
      send_frame(8'h11, 1'b1, -1);
      send_frame(8'h22, 1'b1, -1);
      check("ovr_data", {24'b0, rd_data_out}, 32'h11);
      check("ovr_valid", {31'b0, valid_out}, 32'd1);
      check("ovr_flag", {31'b0, rx_overrun_out}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("ovr_cleared", {31'b0, rx_overrun_out}, 32'd0);

      // Read on the completion edge (2 sync + half bit + 8 bits + stop) admits the new byte
      send_frame(8'h11, 1'b1, -1);
      send_frame(8'h22, 1'b1, 2 + HALF + 9 * C);
      check("rdce_data", {24'b0, rd_data_out}, 32'h22);
      check("rdce_valid", {31'b0, valid_out}, 32'd1);
      check("rdce_ovr", {31'b0, rx_overrun_out}, 32'd0);
      read_pulse();
      check("rdce_consumed", {31'b0, valid_out}, 32'd0);

      // Two-clock low glitch is rejected
      fe0 = fe_cnt;
      rx_drv = 1'b0;
      tick();
      tick();
      rx_drv = 1'b1;
      for (int g = 0; g < 12 * C; g++) tick();
      check("glitch_valid", {31'b0, valid_out}, 32'd0);
      check("glitch_ovr", {31'b0, rx_overrun_out}, 32'd0);
      check("glitch_ferr", fe_cnt - fe0, 0);

      // Frame error: stop bit low
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, -1);
      for (int g = 0; g < 3 * C; g++) tick();
      check("ferr_pulses", fe_cnt - fe0, 1);
      check("ferr_valid", {31'b0, valid_out}, 32'd0);
      check("ferr_data", {24'b0, rd_data_out}, 32'h22);
      check("ferr_ovr", {31'b0, rx_overrun_out}, 32'd0);

      // Random RX bytes
      for (int unsigned i = 0; i < 4; i++) begin
         rb = 8'($urandom);
         send_frame(rb, 1'b1, -1);
         check($sformatf("rxr_valid%0d", i), {31'b0, valid_out}, 32'd1);
         check($sformatf("rxr_data%0d", i), {24'b0, rd_data_out}, {24'b0, rb});
         read_pulse();
         check($sformatf("rxr_clr%0d", i), {31'b0, valid_out}, 32'd0);
      end
      check("rxr_ovr", {31'b0, rx_overrun_out}, 32'd0);

      // Loopback with reset in the middle of a data bit
      loop = 1'b1;
      for (int g = 0; g < 4; g++) tick();
      push(8'hC3);
      for (int g = 0; g < 3 * C + 2; g++) tick();
      reset = 1'b0;
      tick();
      check("lb_rst_line", {31'b0, uart_tx_out}, 32'd1);
      check("lb_rst_ready", {31'b0, ready_out}, 32'd1);
      check("lb_rst_busy", {31'b0, tx_busy_out}, 32'd0);
      check("lb_rst_valid", {31'b0, valid_out}, 32'd0);
      reset = 1'b1;
      for (int g = 0; g < 2 * C; g++) tick();
      check("lb_post_line", {31'b0, uart_tx_out}, 32'd1);
      check("lb_post_busy", {31'b0, tx_busy_out}, 32'd0);
      check("lb_post_valid", {31'b0, valid_out}, 32'd0);
      clear_streams();
      fe0 = fe_cnt;
      push(8'h7E);
      wait_valid(12 * C + 20, "lb_wait");
      check("lb_data", {24'b0, rd_data_out}, 32'h7E);
      check("lb_ovr", {31'b0, rx_overrun_out}, 32'd0);
      wait_idle(12 * C, "lb_idle");
      check("lb_ferr", fe_cnt - fe0, 0);
      compare_stream("lb");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
